traffic_lights_cmd_parser: RTL and testbench

//  Byte-stream command front end for traffic_lights. Assembles 1- or 3-byte host frames into

---
 rtl/traffic_lights_pkg.sv | 42 ++++
 rtl/traffic_lights_cmd_timer.sv | 24 ++
 rtl/traffic_lights_cmd_parser.sv | 181 ++++++++++++++++++
 tb/tb_traffic_lights_cmd_parser.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_lights_pkg.sv
// Shared types for traffic_lights and its byte-stream command parser.
package traffic_lights_pkg;

  localparam int CMD_SIZE  = 3;
  localparam int DATA_SIZE = 16;

  typedef enum logic [CMD_SIZE-1:0] {
    CMD_RUN        = 3'd0,
    CMD_OFF        = 3'd1,
    CMD_NOTRANS    = 3'd2,
    CMD_SET_GREEN  = 3'd3,
    CMD_SET_RED    = 3'd4,
    CMD_SET_YELLOW = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    ERR_HDR     = 2'd0,
    ERR_TYPE    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_MODE    = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_OFF     = 2'd1,
    MODE_NOTRANS = 2'd2
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA_HI = 3'd1,
    ST_DATA_LO = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_GAP     = 3'd4
  } parse_state_t;

  // Types 3..5 carry a 16-bit period in two trailing bytes.
  function automatic logic is_long_cmd(input logic [CMD_SIZE-1:0] t);
    return (t == CMD_SET_GREEN) || (t == CMD_SET_RED) || (t == CMD_SET_YELLOW);
  endfunction

endpackage

// File: rtl/traffic_lights_cmd_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
module traffic_lights_cmd_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk_i) begin
    if (srst_i)                        cnt_q <= '0;
    else if (load)                     cnt_q <= load_val;
    else if (dec && (cnt_q != '0))     cnt_q <= cnt_q - 1'b1;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/traffic_lights_cmd_parser.sv
// Byte-stream command front end for traffic_lights.
// Assembles 1- or 3-byte frames into one-cycle cmd strobes, flags bad frames
// with an error strobe, and holds off the host for MIN_GAP_CYCLES after each command.
// Build option: TRAFFIC_LIGHTS_CMD_PARITY_EN enables the header parity check.
module traffic_lights_cmd_parser
  import traffic_lights_pkg::*;
#(
  parameter logic [3:0] SYNC_NIBBLE    = 4'hA,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         MIN_GAP_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [7:0]           byte_data_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic [CMD_SIZE-1:0]  cmd_type_o,
  output logic                 cmd_valid_o,
  output logic [DATA_SIZE-1:0] cmd_data_o,
  output logic                 frame_err_o,
  output logic [1:0]           err_code_o
);

  // Timer is loaded with N-1 so that done marks the Nth cycle of the wait.
  localparam int TO_LOAD_I  = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int GAP_LOAD_I = (MIN_GAP_CYCLES > 0) ? MIN_GAP_CYCLES - 1 : 0;
  localparam int MAX_LOAD   = (TO_LOAD_I > GAP_LOAD_I) ? TO_LOAD_I : GAP_LOAD_I;
  localparam int TMR_RAW    = $clog2(MAX_LOAD + 1);
  localparam int TMR_W      = (TMR_RAW < 1) ? 1 : ((TMR_RAW > 16) ? 16 : TMR_RAW);
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TO_LOAD_I);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_LOAD_I);

  parse_state_t         state_q, state_d;
  logic                 hs, hdr_ok;
  logic [CMD_SIZE-1:0]  hdr_type, type_q, issue_type;
  logic [7:0]           hi_q;
  logic [DATA_SIZE-1:0] issue_data;
  mode_t                mode_q;
  err_t                 err_code_q, err_code_d;
  logic                 issue_d, err_d, latch_hdr, latch_hi;
  logic                 tmr_load, tmr_dec, tmr_done;
  logic [TMR_W-1:0]     tmr_load_val;

  assign hs           = byte_valid_i & byte_ready_o;
  assign byte_ready_o = (state_q != ST_ISSUE) && (state_q != ST_GAP);
  assign hdr_type     = byte_data_i[2:0];
  assign err_code_o   = err_code_q;

`ifdef TRAFFIC_LIGHTS_CMD_PARITY_EN
  // Parity bit is the complement of the XOR of the type bits (A2 valid, AA invalid).
  assign hdr_ok = (byte_data_i[7:4] == SYNC_NIBBLE) && (byte_data_i[3] == ~^byte_data_i[2:0]);
`else
  logic unused_parity_bit;
  assign unused_parity_bit = byte_data_i[3];
  assign hdr_ok = (byte_data_i[7:4] == SYNC_NIBBLE);
`endif

  traffic_lights_cmd_timer #(.WIDTH(TMR_W)) u_timer (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  // Frame sequencing, timeout/gap timing and strobe requests for the next cycle.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = TO_LOAD;
    tmr_dec      = 1'b0;
    issue_d      = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    latch_hdr    = 1'b0;
    latch_hi     = 1'b0;
    issue_type   = type_q;
    issue_data   = {hi_q, byte_data_i};
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (!hdr_ok) begin
            err_d      = 1'b1;
            err_code_d = ERR_HDR;
          end else if (hdr_type > CMD_SET_YELLOW) begin
            err_d      = 1'b1;
            err_code_d = ERR_TYPE;
          end else if (is_long_cmd(hdr_type)) begin
            latch_hdr = 1'b1;
            tmr_load  = 1'b1;
            state_d   = ST_DATA_HI;
          end else begin
            issue_d    = 1'b1;
            issue_type = hdr_type;
            issue_data = '0;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_DATA_HI: begin
        if (hs) begin
          latch_hi = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_DATA_LO;
        end else if (tmr_done) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DATA_LO: begin
        if (hs) begin
          if (mode_q != MODE_NOTRANS) begin
            err_d      = 1'b1;
            err_code_d = ERR_MODE;
            state_d    = ST_IDLE;
          end else begin
            issue_d = 1'b1;
            state_d = ST_ISSUE;
          end
        end else if (tmr_done) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (MIN_GAP_CYCLES > 0) begin
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
          state_d      = ST_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (tmr_done) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, frame buffers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= ST_IDLE;
      type_q      <= '0;
      hi_q        <= '0;
      mode_q      <= MODE_NOTRANS;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
      frame_err_o <= 1'b0;
      err_code_q  <= ERR_HDR;
    end else begin
      state_q     <= state_d;
      cmd_valid_o <= issue_d;
      frame_err_o <= err_d;
      if (latch_hdr) type_q <= hdr_type;
      if (latch_hi)  hi_q   <= byte_data_i;
      if (err_d)     err_code_q <= err_code_d;
      if (issue_d) begin
        cmd_type_o <= issue_type;
        cmd_data_o <= issue_data;
        case (issue_type)
          CMD_RUN:     mode_q <= MODE_RUN;
          CMD_OFF:     mode_q <= MODE_OFF;
          CMD_NOTRANS: mode_q <= MODE_NOTRANS;
          default:     mode_q <= mode_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_lights_cmd_parser.sv
// Directed bench for traffic_lights_cmd_parser (default parameters).
module tb_traffic_lights_cmd_parser;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [2:0]  cmd_type_o;
  logic        cmd_valid_o;
  logic [15:0] cmd_data_o;
  logic        frame_err_o;
  logic [1:0]  err_code_o;

  int checks = 0;
  int errors = 0;

  traffic_lights_cmd_parser dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .byte_data_i  (byte_data_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .cmd_type_o   (cmd_type_o),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_data_o   (cmd_data_o),
    .frame_err_o  (frame_err_o),
    .err_code_o   (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Waits (bounded) for ready, then presents one byte for exactly one handshake.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!byte_ready_o && n < 50) begin step(); n++; end
    checks++;
    if (byte_ready_o !== 1'b1) begin
      errors++; $display("FAIL ready_wait byte %h: ready=%b required 1", b, byte_ready_o);
    end
    byte_data_i = b; byte_valid_i = 1'b1;
    step();
    byte_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    srst_i = 1'b1; step(); step(); srst_i = 1'b0;
    checks++;
    if ({byte_ready_o, cmd_valid_o, cmd_type_o, cmd_data_o, frame_err_o, err_code_o} !== {1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL reset rdy=%b vld=%b type=%0d data=%h err=%b code=%0d required 1 0 0 0000 0 0",
                         byte_ready_o, cmd_valid_o, cmd_type_o, cmd_data_o, frame_err_o, err_code_o);
    end
  endtask

  task automatic test_short_cmd_gap();
    int low = 1;
    send_byte(8'hA2);
    checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_data_o, byte_ready_o} !== {1'b1, 3'd2, 16'h0, 1'b0}) begin
      errors++; $display("FAIL short_issue vld=%b type=%0d data=%h rdy=%b required 1 2 0000 0",
                         cmd_valid_o, cmd_type_o, cmd_data_o, byte_ready_o);
    end
    step();
    checks++;
    if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL strobe_width vld=%b required 0", cmd_valid_o); end
    while (!byte_ready_o && low < 20) begin low++; step(); end
    checks++;
    if (low != 5) begin errors++; $display("FAIL gap_len ready low %0d cycles required 5", low); end
  endtask

  task automatic test_long_cmd();
    send_byte(8'hA3);
    send_byte(8'h12);
    checks++;
    if (cmd_valid_o !== 1'b0) begin errors++; $display("FAIL long_early vld=%b required 0", cmd_valid_o); end
    send_byte(8'h34);
    checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_data_o} !== {1'b1, 3'd3, 16'h1234}) begin
      errors++; $display("FAIL long_issue vld=%b type=%0d data=%h required 1 3 1234", cmd_valid_o, cmd_type_o, cmd_data_o);
    end
  endtask

  task automatic test_mode_error();
    send_byte(8'hA0);
    checks++;
    if ({cmd_valid_o, cmd_type_o} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL run_issue vld=%b type=%0d required 1 0", cmd_valid_o, cmd_type_o);
    end
    send_byte(8'hA4); send_byte(8'h00); send_byte(8'h0A);
    checks++;
    if ({cmd_valid_o, frame_err_o, err_code_o, cmd_type_o, cmd_data_o} !== {1'b0, 1'b1, 2'd3, 3'd0, 16'h0}) begin
      errors++; $display("FAIL mode_err vld=%b err=%b code=%0d type=%0d data=%h required 0 1 3 0 0000",
                         cmd_valid_o, frame_err_o, err_code_o, cmd_type_o, cmd_data_o);
    end
    checks++;
    if (byte_ready_o !== 1'b1) begin errors++; $display("FAIL mode_err_nogap rdy=%b required 1", byte_ready_o); end
    send_byte(8'hA2);  // back to NOTRANS for the following scenarios
  endtask

  task automatic test_hdr_errors();
    send_byte(8'h5A);
    checks++;
    if ({cmd_valid_o, frame_err_o, err_code_o} !== {1'b0, 1'b1, 2'd0}) begin
      errors++; $display("FAIL sync_err vld=%b err=%b code=%0d required 0 1 0", cmd_valid_o, frame_err_o, err_code_o);
    end
    send_byte(8'hA7);
    checks++;
    if ({cmd_valid_o, frame_err_o, err_code_o} !== {1'b0, 1'b1, 2'd1}) begin
      errors++; $display("FAIL type_err vld=%b err=%b code=%0d required 0 1 1", cmd_valid_o, frame_err_o, err_code_o);
    end
    step();
    checks++;
    if ({frame_err_o, err_code_o, cmd_type_o} !== {1'b0, 2'd1, 3'd2}) begin
      errors++; $display("FAIL err_hold err=%b code=%0d type=%0d required 0 1 2", frame_err_o, err_code_o, cmd_type_o);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    send_byte(8'hA5); send_byte(8'h01);
    for (int i = 0; i < 999; i++) begin
      if (frame_err_o !== 1'b0 || cmd_valid_o !== 1'b0) early++;
      step();
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL timeout_early %0d strobe cycles required 0", early); end
    step();
    checks++;
    if ({frame_err_o, err_code_o, cmd_valid_o, byte_ready_o} !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
      errors++; $display("FAIL timeout err=%b code=%0d vld=%b rdy=%b required 1 2 0 1",
                         frame_err_o, err_code_o, cmd_valid_o, byte_ready_o);
    end
    send_byte(8'hA5); send_byte(8'h01);
    for (int i = 0; i < 999; i++) step();
    send_byte(8'h02);  // handshake lands in the expiry cycle
    checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_data_o, frame_err_o} !== {1'b1, 3'd5, 16'h0102, 1'b0}) begin
      errors++; $display("FAIL expiry_hs vld=%b type=%0d data=%h err=%b required 1 5 0102 0",
                         cmd_valid_o, cmd_type_o, cmd_data_o, frame_err_o);
    end
  endtask

  task automatic test_midframe_reset();
    int strobes = 0;
    send_byte(8'hA3); send_byte(8'h12);
    srst_i = 1'b1; step(); srst_i = 1'b0;
    checks++;
    if ({byte_ready_o, cmd_valid_o, cmd_type_o, cmd_data_o, frame_err_o, err_code_o} !== {1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL srst_mid rdy=%b vld=%b type=%0d data=%h err=%b code=%0d required 1 0 0 0000 0 0",
                         byte_ready_o, cmd_valid_o, cmd_type_o, cmd_data_o, frame_err_o, err_code_o);
    end
    for (int i = 0; i < 3; i++) begin step(); if (cmd_valid_o || frame_err_o) strobes++; end
    checks++;
    if (strobes != 0) begin errors++; $display("FAIL srst_quiet %0d strobes required 0", strobes); end
    send_byte(8'hA2);
    checks++;
    if ({cmd_valid_o, cmd_type_o} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL post_srst vld=%b type=%0d required 1 2", cmd_valid_o, cmd_type_o);
    end
    send_byte(8'hAA);
`ifdef TRAFFIC_LIGHTS_CMD_PARITY_EN
    checks++;
    if ({cmd_valid_o, frame_err_o, err_code_o} !== {1'b0, 1'b1, 2'd0}) begin
      errors++; $display("FAIL parity_err vld=%b err=%b code=%0d required 0 1 0", cmd_valid_o, frame_err_o, err_code_o);
    end
`else
    checks++;
    if ({cmd_valid_o, cmd_type_o, frame_err_o} !== {1'b1, 3'd2, 1'b0}) begin
      errors++; $display("FAIL bit3_ignored vld=%b type=%0d err=%b required 1 2 0", cmd_valid_o, cmd_type_o, frame_err_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_short_cmd_gap();
    test_long_cmd();
    test_mode_error();
    test_hdr_errors();
    test_timeout();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
